// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver. Scans NDIGITS nibbles onto a shared segment bus
// with tear-free double-buffered loads, leading-zero blanking, decimal points and blink.
module seg7_scan_driver #(
    parameter int NDIGITS      = 4,
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic                   clk_2,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    input  logic [NDIGITS-1:0]     dp,
    input  logic                   blank_lz,
    input  logic                   blink_en,
    output logic [7:0]             SEG,
    output logic [NDIGITS-1:0]     digit_sel,
    output logic                   frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]          pre_reg;
    logic [IW-1:0]          idx_reg;
    logic [BW-1:0]          blink_cnt_reg;
    logic                   blink_phase_reg;
    logic [4*NDIGITS-1:0]   shadow_reg;
    logic [NDIGITS-1:0]     shadow_dp_reg;
    logic [4*NDIGITS-1:0]   active_reg;
    logic [NDIGITS-1:0]     dp_act_reg;
    logic                   pending_reg;
    logic                   wrap_reg;

    logic                   scan_tc;
    logic                   boundary;
    logic [3:0]             act_nib [NDIGITS];
    logic [NDIGITS-1:0]     blank_mask;
    logic [3:0]             cur_nib;
    logic [6:0]             glyph;
    logic [7:0]             seg_next;
    logic [NDIGITS-1:0]     sel_next;

    assign scan_tc  = (pre_reg == PRE_LAST);
    assign boundary = scan_tc && (idx_reg == IDX_LAST);

    // A digit is a leading zero when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
            assign act_nib[gi] = active_reg[4*gi +: 4];
            if (gi == 0) begin : g_units
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask[gi] = blank_lz && (active_reg[4*NDIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    always_comb begin
        cur_nib = act_nib[idx_reg];
        case (cur_nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
        seg_next = {dp_act_reg[idx_reg], blank_mask[idx_reg] ? 7'h00 : glyph};
        if (blink_en && blink_phase_reg) begin
            seg_next = 8'h00;
        end
        sel_next = '0;
        sel_next[idx_reg] = 1'b1;
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            pre_reg         <= '0;
            idx_reg         <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            shadow_reg      <= '0;
            shadow_dp_reg   <= '0;
            active_reg      <= '0;
            dp_act_reg      <= '0;
            pending_reg     <= 1'b0;
            wrap_reg        <= 1'b0;
            SEG             <= 8'h00;
            digit_sel       <= '0;
            frame_done      <= 1'b0;
        end else begin
            pre_reg <= scan_tc ? '0 : pre_reg + PW'(1);
            if (scan_tc) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end

            if (boundary) begin
                if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BW'(1);
                end
            end

            // Display data only changes at the frame boundary; a load on that cycle bypasses the shadow.
            if (load) begin
                shadow_reg    <= value;
                shadow_dp_reg <= dp;
            end
            if (boundary && load) begin
                active_reg  <= value;
                dp_act_reg  <= dp;
                pending_reg <= 1'b0;
            end else if (boundary && pending_reg) begin
                active_reg  <= shadow_reg;
                dp_act_reg  <= shadow_dp_reg;
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end

            wrap_reg   <= boundary;
            frame_done <= wrap_reg;
            SEG        <= seg_next;
            digit_sel  <= sel_next;
        end
    end
endmodule
